sine_seq_ctrl: RTL and testbench

Sequencer for the sine wave generator datapath. Runs a phase accumulator, maps each phase to a quarter-wave LUT address plus quadrant, and drives the 16-bit two-input sample mux select: input 0 carries the positive LUT sample and input 1 the negated sample. It delivers one sample per accepted valid/ready handshake, aligned with the synchronous ROM output. It sits between the frequency-control registers and the LUT/negate/mux datapath.

---
 rtl/sine_pkg.sv | 31 +++
 rtl/sine_phase_map.sv | 30 +++
 rtl/sine_seq_ctrl.sv | 99 +++++++++
 tb/tb_sine_seq_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared types and defaults for the sine wave sequencer: widths, FSM states,
// quadrant type and a phase-to-{address, select} mapping helper.
package sine_pkg;

    localparam int SINE_PHASE_W = 16;
    localparam int SINE_ADDR_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_t;

    typedef logic [1:0] quadrant_t;

    typedef struct packed {
        logic [SINE_ADDR_W-1:0] addr;
        logic                   sel;
    } phase_map_t;

    // Odd quadrants walk the quarter-wave table backwards; the upper half-wave is negated.
    function automatic phase_map_t map_phase(input logic [SINE_PHASE_W-1:0] p);
        quadrant_t              q;
        logic [SINE_ADDR_W-1:0] a;
        q = p[SINE_PHASE_W-1 -: 2];
        a = p[SINE_PHASE_W-3 -: SINE_ADDR_W];
        map_phase.addr = q[0] ? ~a : a;
        map_phase.sel  = q[1];
    endfunction

endpackage

// File: rtl/sine_phase_map.sv
// Combinational phase mapper: splits a phase into quarter-wave LUT address
// and the sample mux select (negate for the second half-wave).
module sine_phase_map
    import sine_pkg::*;
#(
    parameter int PHASE_W = SINE_PHASE_W,
    parameter int ADDR_W  = SINE_ADDR_W
) (
    input  logic [PHASE_W-1:0] phase,
    output logic [ADDR_W-1:0]  addr,
    output logic               sel
);

    quadrant_t         quad;
    logic [ADDR_W-1:0] fine;

    assign quad = phase[PHASE_W-1 -: 2];
    assign fine = phase[PHASE_W-3 -: ADDR_W];
    assign addr = quad[0] ? ~fine : fine;
    assign sel  = quad[1];

    // Phase bits below the table resolution only matter to the accumulator.
    generate
        if (PHASE_W > ADDR_W + 2) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^phase[PHASE_W-3-ADDR_W:0];
        end
    endgenerate

endmodule

// File: rtl/sine_seq_ctrl.sv
// Sine generator sequencer: phase accumulator, LUT addressing and mux select.
// Optional SINE_SEQ_PHASE_OFS_EN adds a phase_ofs input applied to the mapping only.
module sine_seq_ctrl
    import sine_pkg::*;
#(
    parameter int PHASE_W = SINE_PHASE_W,
    parameter int ADDR_W  = SINE_ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_load,
`ifdef SINE_SEQ_PHASE_OFS_EN
    input  logic [PHASE_W-1:0] phase_ofs,
`endif
    output logic [ADDR_W-1:0]  lut_addr,
    output logic               mux_sel,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               phase_wrap
);

    seq_state_t         state, state_nxt;
    logic [PHASE_W-1:0] phase, phase_nxt, ftw_reg, map_in;
    logic [PHASE_W:0]   phase_sum;
    logic               fire, sel_nxt;

    assign sample_valid = (state != IDLE);
    assign fire         = sample_valid & sample_ready;
    assign phase_sum    = {1'b0, phase} + {1'b0, ftw_reg};

    // phase_nxt is the value the phase register takes at the next edge, so the
    // ROM read issued from it lines up with the phase register one cycle later.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        unique case (state)
            IDLE: begin
                phase_nxt = '0;
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (fire) phase_nxt = phase_sum[PHASE_W-1:0];
                if (!en) begin
                    if (fire) begin
                        state_nxt = IDLE;
                        phase_nxt = '0;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fire) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

`ifdef SINE_SEQ_PHASE_OFS_EN
    assign map_in = phase_nxt + phase_ofs;
`else
    assign map_in = phase_nxt;
`endif

    sine_phase_map #(
        .PHASE_W(PHASE_W),
        .ADDR_W (ADDR_W)
    ) u_map (
        .phase(map_in),
        .addr (lut_addr),
        .sel  (sel_nxt)
    );

    // A load sharing an edge with a fire lets that fire use the old tuning word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            ftw_reg    <= '0;
            mux_sel    <= 1'b0;
            phase_wrap <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            mux_sel    <= sel_nxt;
            phase_wrap <= fire & phase_sum[PHASE_W];
            if (ftw_load) ftw_reg <= ftw;
        end
    end

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Scoreboard bench for sine_seq_ctrl: a behavioural model predicts each sample
// and a monitor compares what the DUT presents, with a stand-in synchronous ROM.
module tb_sine_seq_ctrl;

    localparam int PW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [PW-1:0] ftw = '0;
    logic          ftw_load = 1'b0;
    logic [AW-1:0] lut_addr;
    logic          mux_sel;
    logic          sample_valid;
    logic          sample_ready = 1'b0;
    logic          phase_wrap;
    logic [AW-1:0] rom_q;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int addr;
        int sel;
    } exp_t;
    exp_t exp_q[$];

    bit m_valid = 1'b0;
    bit m_stopping = 1'b0;
    bit m_wrap = 1'b0;
    int m_phase = 0;
    int m_ftw = 0;
    bit exp_valid_now = 1'b0;
    bit exp_wrap_now = 1'b0;

    sine_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ftw         (ftw),
        .ftw_load    (ftw_load),
`ifdef SINE_SEQ_PHASE_OFS_EN
        .phase_ofs   (16'h0000),
`endif
        .lut_addr    (lut_addr),
        .mux_sel     (mux_sel),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .phase_wrap  (phase_wrap)
    );

    always #5 clk = ~clk;

    // ROM stand-in whose data is simply the address it was given.
    always @(posedge clk) rom_q <= lut_addr;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Quarter-wave mapping written from the waveform's point of view.
    function automatic exp_t sineRef(input int p);
        exp_t e;
        int   q, a;
        q = p / 16384;
        a = (p / 256) % 64;
        e.addr = (q % 2 == 1) ? 63 - a : a;
        e.sel  = q / 2;
        return e;
    endfunction

    // Drives one cycle of inputs and advances the model to the following edge.
    task automatic applyStimulus(input bit en_i, input bit rdy_i, input bit load_i, input int ftw_i);
        int sum;
        @(posedge clk);
        #1;
        en = en_i;
        sample_ready = rdy_i;
        ftw_load = load_i;
        ftw = PW'(ftw_i);
        exp_valid_now = m_valid;
        exp_wrap_now = m_wrap;
        m_wrap = 1'b0;
        if (!m_valid) begin
            if (en_i) begin
                m_valid = 1'b1;
                m_phase = 0;
                exp_q.push_back(sineRef(0));
            end
        end else if (rdy_i) begin
            sum = m_phase + m_ftw;
            m_wrap = (sum >= 65536);
            if (m_stopping || !en_i) begin
                m_valid = 1'b0;
                m_stopping = 1'b0;
                m_phase = 0;
            end else begin
                m_phase = sum % 65536;
                exp_q.push_back(sineRef(m_phase));
            end
        end else if (!en_i) begin
            m_stopping = 1'b1;
        end
        if (load_i) m_ftw = ftw_i & 32'h0000_FFFF;
    endtask

    task automatic asyncResetCheck();
        @(posedge clk);
        #3;
        checkOutput("pre_reset_valid", int'(sample_valid), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", int'(sample_valid), 0);
        checkOutput("async_rst_addr", int'(lut_addr), 0);
        checkOutput("async_rst_sel", int'(mux_sel), 0);
        checkOutput("async_rst_wrap", int'(phase_wrap), 0);
        en = 1'b0;
        sample_ready = 1'b0;
        ftw_load = 1'b0;
        exp_q.delete();
        m_valid = 1'b0;
        m_stopping = 1'b0;
        m_wrap = 1'b0;
        m_phase = 0;
        m_ftw = 0;
        exp_valid_now = 1'b0;
        exp_wrap_now = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compares the presented sample every cycle, consumes it on fire.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("sample_valid", int'(sample_valid), int'(exp_valid_now));
                checkOutput("phase_wrap", int'(phase_wrap), int'(exp_wrap_now));
                if (sample_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_sample: got addr %0d, expected no sample at %0t", rom_q, $time);
                    end else begin
                        checkOutput("sample_addr", int'(rom_q), exp_q[0].addr);
                        checkOutput("sample_sel", int'(mux_sel), exp_q[0].sel);
                        if (sample_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    checkOutput("idle_lut_addr", int'(lut_addr), 0);
                    checkOutput("idle_mux_sel", int'(mux_sel), 0);
                end
            end
        end
    end

    initial begin
        #12;
        checkOutput("reset_addr", int'(lut_addr), 0);
        checkOutput("reset_sel", int'(mux_sel), 0);
        checkOutput("reset_valid", int'(sample_valid), 0);
        checkOutput("reset_wrap", int'(phase_wrap), 0);
        rst_n = 1'b1;

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 'h0400);
        repeat (70) applyStimulus(1'b1, 1'b1, 1'b0, 0);

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 0);

        applyStimulus(1'b1, 1'b1, 1'b1, 'h0800);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 0);

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 0);

        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        asyncResetCheck();
        repeat (8) applyStimulus(1'b1, bit'($urandom_range(0, 1)), 1'b0, 0);

        repeat (1500) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 19) == 0, int'($urandom));
        end

        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        #1;
        checkOutput("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
